// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and helpers for the memory arbiter.
// The optional watchdog is enabled with the MEM_ARB_TIMEOUT_EN macro in mem_arbiter.
package mem_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Width of a port index: clog2 of the port count, never below one bit.
    function automatic int port_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and memory-side signals of the arbiter.
//
// Handshake: a requester holds HTRANS[i] (with its HADDR/HWRITE/HWDATA) high
// until it sees a one-cycle HREADY[i]; HERR/HRDATA are valid only with that
// pulse. On the memory side PSEL stays high with stable PADDR/PWRITE/PDATA
// until PREADY is seen high in a PSEL cycle; PREADY outside PSEL is ignored.
interface mem_arbiter_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64
);
    logic [NUM_PORTS-1:0]        HTRANS;
    logic [NUM_PORTS*ADDR_W-1:0] HADDR;
    logic [NUM_PORTS-1:0]        HWRITE;
    logic [NUM_PORTS*DATA_W-1:0] HWDATA;
    logic [NUM_PORTS-1:0]        HREADY;
    logic [NUM_PORTS-1:0]        HERR;
    logic [DATA_W-1:0]           HRDATA;
    logic [NUM_PORTS-1:0]        stall;
    logic                        PSEL;
    logic [ADDR_W-1:0]           PADDR;
    logic                        PWRITE;
    logic [DATA_W-1:0]           PDATA;
    logic [DATA_W-1:0]           PRDATA;
    logic                        PREADY;

    // The arbiter itself.
    modport slave (
        input  HTRANS, HADDR, HWRITE, HWDATA, PRDATA, PREADY,
        output HREADY, HERR, HRDATA, stall, PSEL, PADDR, PWRITE, PDATA
    );

    // The environment around the arbiter: requesters plus the memory.
    modport master (
        output HTRANS, HADDR, HWRITE, HWDATA, PRDATA, PREADY,
        input  HREADY, HERR, HRDATA, stall, PSEL, PADDR, PWRITE, PDATA
    );
endinterface

// File: rtl/mem_arb_picker.sv
// mem_arb_picker: first asserted request at or after 'start', wrapping around.
// Fixed priority uses start = 0; round-robin uses last_grant + 1.
import mem_arb_pkg::*;

module mem_arb_picker #(
    parameter int NUM_PORTS = 2,
    parameter int IW        = port_idx_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IW-1:0]        start,
    output logic [IW-1:0]        idx,
    output logic                 valid
);

    int j;

    // Scan the ports in circular order from start and keep the first hit.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            j = int'(start) + k;
            if (j >= NUM_PORTS) j = j - NUM_PORTS;
            if (!valid && req[j]) begin
                valid = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: N-port arbiter in front of a single memory port.
// Define MEM_ARB_TIMEOUT_EN to enable the BUSY watchdog (TIMEOUT_CYCLES).
import mem_arb_pkg::*;

module mem_arbiter #(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int ROUND_ROBIN    = 0,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic          HCLK,
    input  logic          HRESET,
    mem_arbiter_if.slave  bus,
    output arb_state_e    state
);

    localparam int IW = port_idx_w(NUM_PORTS);

    arb_state_e           state_q;
    logic [IW-1:0]        grant;
    logic [IW-1:0]        last_grant;
    logic [IW-1:0]        rr_start;
    logic [IW-1:0]        start;
    logic [IW-1:0]        pick_idx;
    logic                 pick_valid;
    logic [ADDR_W-1:0]    paddr;
    logic                 pwrite;
    logic [DATA_W-1:0]    pdata;
    logic                 busy;
    logic                 timeout;
    logic                 complete;
    logic [NUM_PORTS-1:0] hready;
    logic [NUM_PORTS-1:0] herr;

    assign busy     = (state_q == ARB_BUSY);
    assign rr_start = (last_grant == IW'(NUM_PORTS - 1)) ? '0 : last_grant + IW'(1);
    assign start    = (ROUND_ROBIN != 0) ? rr_start : '0;
    // A watchdog expiry completes the transaction just like PREADY does.
    assign complete = busy && (bus.PREADY || timeout);

    mem_arb_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IW        (IW)
    ) u_picker (
        .req   (bus.HTRANS),
        .start (start),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [WW-1:0] wdog;

    assign timeout = busy && (wdog == WW'(TIMEOUT_CYCLES - 1));

    // Count BUSY cycles without PREADY; cleared whenever a new grant is made.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wdog <= '0;
        end else if (!busy && pick_valid) begin
            wdog <= '0;
        end else if (busy && !bus.PREADY) begin
            wdog <= wdog + WW'(1);
        end
    end
`else
    // Without the watchdog BUSY waits for PREADY indefinitely.
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
    assign timeout = 1'b0;
`endif

    // IDLE grabs the winner and latches its request; BUSY waits for completion.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= ARB_IDLE;
            grant      <= '0;
            last_grant <= IW'(NUM_PORTS - 1);
            paddr      <= '0;
            pwrite     <= 1'b0;
            pdata      <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        state_q    <= ARB_BUSY;
                        grant      <= pick_idx;
                        last_grant <= pick_idx;
                        paddr      <= bus.HADDR[int'(pick_idx)*ADDR_W +: ADDR_W];
                        pwrite     <= bus.HWRITE[pick_idx];
                        pdata      <= bus.HWDATA[int'(pick_idx)*DATA_W +: DATA_W];
                    end
                end
                ARB_BUSY: begin
                    if (complete) state_q <= ARB_IDLE;
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    // Completion pulse to the winner; error only when the watchdog beat PREADY.
    always_comb begin
        hready = '0;
        herr   = '0;
        if (complete) begin
            hready[grant] = 1'b1;
            herr[grant]   = timeout && !bus.PREADY;
        end
    end

    assign bus.HREADY = hready;
    assign bus.HERR   = herr;
    assign bus.HRDATA = bus.PRDATA;
    assign bus.stall  = bus.HTRANS & ~hready;
    assign bus.PSEL   = busy;
    assign bus.PADDR  = paddr;
    assign bus.PWRITE = pwrite;
    assign bus.PDATA  = pdata;
    assign state      = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for a 2-port fixed-priority arbiter (dut_a)
// and a 4-port round-robin arbiter (dut_b). Both use TIMEOUT_CYCLES=8.
import mem_arb_pkg::*;

module tb_mem_arbiter;

    logic       clk;
    logic       rst;
    arb_state_e state_a;
    arb_state_e state_b;
    int         n_tests;
    int         n_fail;
    int         exp_q[$];
    int         g;

    mem_arbiter_if #(.NUM_PORTS(2), .ADDR_W(64), .DATA_W(64)) bus_a ();
    mem_arbiter_if #(.NUM_PORTS(4), .ADDR_W(64), .DATA_W(64)) bus_b ();

    mem_arbiter #(
        .NUM_PORTS(2), .ADDR_W(64), .DATA_W(64), .ROUND_ROBIN(0), .TIMEOUT_CYCLES(8)
    ) dut_a (
        .HCLK(clk), .HRESET(rst), .bus(bus_a.slave), .state(state_a)
    );

    mem_arbiter #(
        .NUM_PORTS(4), .ADDR_W(64), .DATA_W(64), .ROUND_ROBIN(1), .TIMEOUT_CYCLES(8)
    ) dut_b (
        .HCLK(clk), .HRESET(rst), .bus(bus_b.slave), .state(state_b)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit
    initial begin
        #200000;
        $display("FAIL time_limit: bench did not finish, observed running expected done");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus_a.HTRANS = '0; bus_a.HADDR = '0; bus_a.HWRITE = '0; bus_a.HWDATA = '0;
        bus_a.PRDATA = '0; bus_a.PREADY = 1'b0;
        bus_b.HTRANS = '0; bus_b.HADDR = '0; bus_b.HWRITE = '0; bus_b.HWDATA = '0;
        bus_b.PRDATA = '0; bus_b.PREADY = 1'b0;

        // ---- reset state
        repeat (2) tick();
        check("rst_psel_a",   64'(bus_a.PSEL),   64'h0);
        check("rst_paddr_a",  bus_a.PADDR,       64'h0);
        check("rst_pwrite_a", 64'(bus_a.PWRITE), 64'h0);
        check("rst_pdata_a",  bus_a.PDATA,       64'h0);
        check("rst_hready_a", 64'(bus_a.HREADY), 64'h0);
        check("rst_herr_a",   64'(bus_a.HERR),   64'h0);
        check("rst_state_b",  64'(state_b),      64'(ARB_IDLE));
        check("rst_psel_b",   64'(bus_b.PSEL),   64'h0);
        rst = 1'b0;
        tick();

        // ---- single write on port 1, PREADY in the third BUSY cycle
        bus_a.HTRANS = 2'b10;
        bus_a.HWRITE = 2'b10;
        bus_a.HADDR[64 +: 64]  = 64'h1000;
        bus_a.HWDATA[64 +: 64] = 64'hDEAD;
        #1;
        check("w_stall_idle", 64'(bus_a.stall), 64'h2);
        check("w_psel_idle",  64'(bus_a.PSEL),  64'h0);
        tick();
        check("w_psel_c1",   64'(bus_a.PSEL),   64'h1);
        check("w_paddr_c1",  bus_a.PADDR,       64'h1000);
        check("w_pwrite_c1", 64'(bus_a.PWRITE), 64'h1);
        check("w_pdata_c1",  bus_a.PDATA,       64'hDEAD);
        check("w_hready_c1", 64'(bus_a.HREADY), 64'h0);
        tick();
        check("w_psel_c2",   64'(bus_a.PSEL),   64'h1);
        check("w_hready_c2", 64'(bus_a.HREADY), 64'h0);
        bus_a.HADDR[64 +: 64] = 64'h5555;
        tick();
        bus_a.PREADY = 1'b1;
        #1;
        check("w_hready_c3", 64'(bus_a.HREADY), 64'h2);
        check("w_herr_c3",   64'(bus_a.HERR),   64'h0);
        check("w_stall_c3",  64'(bus_a.stall),  64'h0);
        check("w_paddr_c3",  bus_a.PADDR,       64'h1000);
        bus_a.HTRANS = 2'b00;
        tick();
        // PREADY still high here while PSEL=0: must be ignored
        check("w_psel_after",   64'(bus_a.PSEL),   64'h0);
        check("w_hready_after", 64'(bus_a.HREADY), 64'h0);
        check("w_paddr_hold",   bus_a.PADDR,       64'h1000);
        check("w_state_after",  64'(state_a),      64'(ARB_IDLE));
        tick();
        check("w_idle_preadyign", 64'(bus_a.HREADY), 64'h0);

        // ---- fixed priority: both request, PREADY tied high
        bus_a.HTRANS = 2'b11;
        bus_a.HWRITE = 2'b00;
        bus_a.HADDR[0 +: 64]  = 64'hA0;
        bus_a.HADDR[64 +: 64] = 64'hB0;
        #1;
        check("fp_stall_start", 64'(bus_a.stall), 64'h3);
        for (int r = 0; r < 3; r++) begin
            tick();
            check("fp_psel_busy", 64'(bus_a.PSEL),   64'h1);
            check("fp_paddr",     bus_a.PADDR,       64'hA0);
            check("fp_hready",    64'(bus_a.HREADY), 64'h1);
            check("fp_stall",     64'(bus_a.stall),  64'h2);
            if (r == 2) bus_a.HTRANS = 2'b00;
            tick();
            check("fp_psel_bubble",   64'(bus_a.PSEL),   64'h0);
            check("fp_hready_bubble", 64'(bus_a.HREADY), 64'h0);
            check("fp_stall_bubble",  64'(bus_a.stall),  (r < 2) ? 64'h3 : 64'h0);
        end
        bus_a.PREADY = 1'b0;

        // ---- round-robin on the 4-port instance
        bus_b.HTRANS = 4'hF;
        for (int i = 0; i < 4; i++) bus_b.HADDR[i*64 +: 64] = 64'h100 * (i + 1);
        bus_b.PREADY = 1'b1;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(0);
        for (int r = 0; r < 5; r++) begin
            tick();
            g = exp_q.pop_front();
            check("rr_hready", 64'(bus_b.HREADY), 64'(4'b0001 << g));
            check("rr_paddr",  bus_b.PADDR,       64'h100 * (g + 1));
            check("rr_stall_count", 64'($countones(bus_b.stall)), 64'd3);
            if (r == 4) bus_b.HTRANS = 4'h0;
            tick();
            check("rr_psel_bubble", 64'(bus_b.PSEL), 64'h0);
        end
        bus_b.PREADY = 1'b0;

        // ---- read return, address change during BUSY ignored
        bus_a.HTRANS = 2'b01;
        bus_a.HWRITE = 2'b00;
        bus_a.HADDR[0 +: 64] = 64'h2000;
        tick();
        check("rd_paddr_c1",  bus_a.PADDR,       64'h2000);
        check("rd_pwrite_c1", 64'(bus_a.PWRITE), 64'h0);
        bus_a.HADDR[0 +: 64]  = 64'h3000;
        bus_a.HWDATA[0 +: 64] = 64'hFFFF;
        #1;
        check("rd_paddr_stable", bus_a.PADDR, 64'h2000);
        tick();
        bus_a.PREADY = 1'b1;
        bus_a.PRDATA = 64'h1234_5678;
        #1;
        check("rd_hrdata",   bus_a.HRDATA,      64'h1234_5678);
        check("rd_hready",   64'(bus_a.HREADY), 64'h1);
        check("rd_paddr_c2", bus_a.PADDR,       64'h2000);
        bus_a.HTRANS = 2'b00;
        tick();
        bus_a.PREADY = 1'b0;
        check("rd_psel_after", 64'(bus_a.PSEL), 64'h0);

        // ---- hung memory
        bus_a.HTRANS = 2'b01;
        bus_a.HADDR[0 +: 64] = 64'h4000;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int c = 1; c <= 7; c++) begin
            tick();
            check("to_hready_wait", 64'(bus_a.HREADY), 64'h0);
        end
        tick();
        check("to_hready_c8", 64'(bus_a.HREADY), 64'h1);
        check("to_herr_c8",   64'(bus_a.HERR),   64'h1);
        bus_a.HTRANS = 2'b00;
        tick();
        check("to_psel_after", 64'(bus_a.PSEL), 64'h0);
        bus_a.HTRANS = 2'b01;
        repeat (8) tick();
        bus_a.PREADY = 1'b1;
        #1;
        check("to_race_hready", 64'(bus_a.HREADY), 64'h1);
        check("to_race_herr",   64'(bus_a.HERR),   64'h0);
        bus_a.HTRANS = 2'b00;
        tick();
        bus_a.PREADY = 1'b0;
        check("to_race_psel_after", 64'(bus_a.PSEL), 64'h0);
`else
        repeat (12) tick();
        check("nt_psel_hold", 64'(bus_a.PSEL),   64'h1);
        check("nt_hready",    64'(bus_a.HREADY), 64'h0);
        check("nt_herr",      64'(bus_a.HERR),   64'h0);
        bus_a.PREADY = 1'b1;
        #1;
        check("nt_hready_done", 64'(bus_a.HREADY), 64'h1);
        check("nt_herr_done",   64'(bus_a.HERR),   64'h0);
        bus_a.HTRANS = 2'b00;
        tick();
        bus_a.PREADY = 1'b0;
        check("nt_psel_after", 64'(bus_a.PSEL), 64'h0);
`endif

        // ---- reset in the second BUSY cycle; round-robin restarts at port 0
        bus_b.HTRANS = 4'hF;
        tick();
        check("rb_paddr_c1", bus_b.PADDR,       64'h200);
        check("rb_psel_c1",  64'(bus_b.PSEL),   64'h1);
        tick();
        bus_b.PREADY = 1'b1;
        rst = 1'b1;
        #1;
        check("rb_psel_rst",   64'(bus_b.PSEL),   64'h0);
        check("rb_hready_rst", 64'(bus_b.HREADY), 64'h0);
        check("rb_paddr_rst",  bus_b.PADDR,       64'h0);
        tick();
        rst = 1'b0;
        tick();
        check("rb_hready_first", 64'(bus_b.HREADY), 64'h1);
        check("rb_paddr_first",  bus_b.PADDR,       64'h100);
        bus_b.HTRANS = 4'h0;
        tick();
        bus_b.PREADY = 1'b0;
        check("rb_psel_after", 64'(bus_b.PSEL), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
